// File: rtl/cassette_recorder.sv
// cassette_recorder
//   Record path of the CoCo cassette port. While the cassette relay (en) is on, the
//   6-bit sound DAC is run through a hysteresis comparator. The time between rising
//   edges of the comparator output is measured in 1 us ticks, and each period is
//   decoded as one FSK bit: a short period (2400 Hz) is 1 and a long period (1200 Hz)
//   is 0. Bits are packed LSB-first, and every completed byte is written to the next
//   cassette SRAM address, in the layout the player reads back.
//
// Ports
//   clk       in   system clock
//   reset_n   in   asynchronous active-low reset
//   en        in   cassette relay; recording enabled while high
//   sound     in   6-bit DAC level
//   rewind    in   level; empties the recording
//   ram_addr  out  SRAM write address
//   ram_din   out  SRAM write data
//   ram_we    out  one-clk write strobe
//   rec_len   out  bytes written since the last rewind/reset
//   active    out  high while measuring bit periods
//   full      out  SRAM full; further bytes are dropped
module cassette_recorder #(
  parameter int TICK_DIV  = 57,
  parameter int HYST_HI   = 36,
  parameter int HYST_LO   = 28,
  parameter int MIN_US    = 200,
  parameter int THRESH_US = 625,
  parameter int MAX_US    = 1500,
  parameter int ADDR_W    = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              en,
  input  logic [5:0]        sound,
  input  logic              rewind,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_din,
  output logic              ram_we,
  output logic [ADDR_W:0]   rec_len,
  output logic              active,
  output logic              full
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0]     TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [10:0]       P_MIN     = 11'(MIN_US);
  localparam logic [10:0]       P_THRESH  = 11'(THRESH_US);
  localparam logic [10:0]       P_LAST    = 11'(MAX_US - 1);
  localparam logic [10:0]       P_SAT     = 11'h7FF;
  localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_MEASURE} state_t;

  state_t            state_q, state_d;
  logic [TW-1:0]     tick_cnt_q, tick_cnt_d;
  logic              lvl_q, lvl_d;
  logic              lvl_prev_q, lvl_prev_d;
  logic [10:0]       period_q, period_d;
  logic [7:0]        shift_q, shift_d;
  logic [2:0]        bitcnt_q, bitcnt_d;
  logic [7:0]        ram_din_q, ram_din_d;
  logic              ram_we_q, ram_we_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [ADDR_W:0]   rec_len_q, rec_len_d;
  logic              full_q, full_d;

  logic              tick;
  logic              boundary;
  logic              dec_bit;
  logic [10:0]       period_inc;
  logic [7:0]        shift_ins;

  always_comb begin
    tick       = (tick_cnt_q == TICK_LAST);
    tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);

    // Hysteresis comparator: levels between the thresholds keep the last decision.
    lvl_d = lvl_q;
    if (sound >= 6'(HYST_HI))      lvl_d = 1'b1;
    else if (sound <= 6'(HYST_LO)) lvl_d = 1'b0;
    lvl_prev_d = lvl_q;
    boundary   = lvl_q & ~lvl_prev_q;

    period_inc = (tick && period_q != P_SAT) ? period_q + 11'd1 : period_q;
    dec_bit    = (period_q < P_THRESH);
    shift_ins  = shift_q;
    shift_ins[bitcnt_q] = dec_bit;

    state_d    = state_q;
    period_d   = period_q;
    shift_d    = shift_q;
    bitcnt_d   = bitcnt_q;
    ram_din_d  = ram_din_q;
    ram_we_d   = 1'b0;
    ram_addr_d = ram_addr_q;
    rec_len_d  = rec_len_q;
    full_d     = full_q;

    // Address and length advance the clk after the strobe; the last address sticks.
    if (ram_we_q) begin
      rec_len_d = rec_len_q + (ADDR_W + 1)'(1);
      if (ram_addr_q == ADDR_LAST) full_d = 1'b1;
      else                         ram_addr_d = ram_addr_q + ADDR_W'(1);
    end

    if (rewind) begin
      // Rewind beats a byte completing in the same clk: that byte is lost.
      ram_addr_d = '0;
      rec_len_d  = '0;
      full_d     = 1'b0;
      bitcnt_d   = '0;
      shift_d    = '0;
      period_d   = '0;
      state_d    = en ? S_ARM : S_IDLE;
    end else if (!en) begin
      state_d  = S_IDLE;
      bitcnt_d = '0;
      shift_d  = '0;
      period_d = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          period_d = '0;
          state_d  = S_ARM;
        end
        S_ARM: begin
          // The arming edge only starts the first period; it carries no bit.
          period_d = '0;
          if (boundary) state_d = S_MEASURE;
        end
        S_MEASURE: begin
          period_d = period_inc;
          // An edge sooner than MIN_US is a glitch; the period keeps running.
          if (boundary && period_q >= P_MIN) begin
            period_d = '0;
            bitcnt_d = bitcnt_q + 3'd1;
            shift_d  = shift_ins;
            if (bitcnt_q == 3'd7) begin
              shift_d = '0;
              if (!full_q) begin
                ram_din_d = shift_ins;
                ram_we_d  = 1'b1;
              end
            end
          end else if (tick && period_q >= P_LAST) begin
            // Silence: drop the partial byte and wait for a new carrier edge.
            period_d = '0;
            bitcnt_d = '0;
            shift_d  = '0;
            state_d  = S_ARM;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      tick_cnt_q <= '0;
      lvl_q      <= 1'b0;
      lvl_prev_q <= 1'b0;
      period_q   <= '0;
      shift_q    <= '0;
      bitcnt_q   <= '0;
      ram_din_q  <= '0;
      ram_we_q   <= 1'b0;
      ram_addr_q <= '0;
      rec_len_q  <= '0;
      full_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      lvl_q      <= lvl_d;
      lvl_prev_q <= lvl_prev_d;
      period_q   <= period_d;
      shift_q    <= shift_d;
      bitcnt_q   <= bitcnt_d;
      ram_din_q  <= ram_din_d;
      ram_we_q   <= ram_we_d;
      ram_addr_q <= ram_addr_d;
      rec_len_q  <= rec_len_d;
      full_q     <= full_d;
    end
  end

  assign ram_addr = ram_addr_q;
  assign ram_din  = ram_din_q;
  assign ram_we   = ram_we_q;
  assign rec_len  = rec_len_q;
  assign full     = full_q;
  assign active   = (state_q == S_MEASURE);

endmodule

// File: tb/tb_cassette_recorder.sv
// tb_cassette_recorder
//   Drives FSK tape waveforms into cassette_recorder and checks the SRAM writes,
//   address, length, full flag and activity against a bit-list reference model.
//   Time constants are scaled by 1/10 and the SRAM shrunk to 4 bytes to keep the run short.
module tb_cassette_recorder;

  localparam int TICK_DIV  = 4;
  localparam int HYST_HI   = 36;
  localparam int HYST_LO   = 28;
  localparam int MIN_US    = 20;
  localparam int THRESH_US = 62;
  localparam int MAX_US    = 150;
  localparam int ADDR_W    = 2;
  localparam int SIL_CLKS  = (MAX_US + 30) * TICK_DIV;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              en;
  logic [5:0]        sound;
  logic              rewind;
  logic [ADDR_W-1:0] ram_addr;
  logic [7:0]        ram_din;
  logic              ram_we;
  logic [ADDR_W:0]   rec_len;
  logic              active;
  logic              full;

  int n_chk = 0;
  int n_err = 0;

  bit         seq[$];
  logic [7:0] wq_data[$];
  int         wq_addr[$];
  logic [7:0] exp_data[$];
  int         exp_addr[$];
  int         m_addr;
  int         m_len;
  bit         m_full;

  cassette_recorder #(
    .TICK_DIV(TICK_DIV), .HYST_HI(HYST_HI), .HYST_LO(HYST_LO), .MIN_US(MIN_US),
    .THRESH_US(THRESH_US), .MAX_US(MAX_US), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk), .reset_n(reset_n), .en(en), .sound(sound), .rewind(rewind),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we), .rec_len(rec_len),
    .active(active), .full(full)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (reset_n && ram_we) begin
      wq_data.push_back(ram_din);
      wq_addr.push_back(int'(ram_addr));
    end
  end

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: every full group of 8 bits is one byte, LSB first; leftovers vanish.
  task automatic model_play();
    logic [7:0] v;
    for (int b = 0; b + 8 <= seq.size(); b += 8) begin
      for (int k = 0; k < 8; k++) v[k] = seq[b + k];
      if (!m_full) begin
        exp_data.push_back(v);
        exp_addr.push_back(m_addr);
        m_len++;
        if (m_addr == (1 << ADDR_W) - 1) m_full = 1'b1;
        else                             m_addr++;
      end
    end
  endtask

  task automatic model_clear();
    m_addr = 0;
    m_len  = 0;
    m_full = 1'b0;
  endtask

  task automatic load_byte(input logic [7:0] b);
    for (int k = 0; k < 8; k++) seq.push_back(b[k]);
  endtask

  task automatic load_rand(input int n);
    for (int k = 0; k < n; k++) seq.push_back(1'($urandom_range(1, 0)));
  endtask

  // One carrier cycle of p ticks: high half then low half, with in-band noise.
  task automatic send_cycle(input int p, input bit glitch);
    for (int i = 0; i < p * TICK_DIV; i++) begin
      @(negedge clk);
      if (i == 0)                            sound = 6'($urandom_range(63, HYST_HI));
      else if (glitch && i >= 20 && i < 28)  sound = 6'($urandom_range(HYST_LO, 0));
      else if (glitch && i == 28)            sound = 6'($urandom_range(63, HYST_HI));
      else if (i < p * TICK_DIV / 2)         sound = 6'($urandom_range(63, HYST_LO + 1));
      else if (i == p * TICK_DIV / 2)        sound = 6'($urandom_range(HYST_LO, 0));
      else                                   sound = 6'($urandom_range(HYST_HI - 1, 0));
    end
  endtask

  task automatic silence(input int n);
    @(negedge clk) sound = 6'($urandom_range(HYST_LO, 0));
    repeat (n) @(negedge clk) sound = 6'($urandom_range(HYST_HI - 1, 0));
  endtask

  // Closing edge delivers the last bit; rw pulses rewind in the clk it is decoded.
  task automatic tail_edge(input bit rw);
    @(negedge clk) sound = 6'($urandom_range(63, HYST_HI));
    if (rw) begin
      @(negedge clk) rewind = 1'b1;
      @(negedge clk) rewind = 1'b0;
    end
    repeat (6) @(negedge clk) sound = 6'($urandom_range(63, HYST_LO + 1));
    silence(SIL_CLKS);
  endtask

  task automatic play(input bit glitchy, input bit rw);
    int p;
    for (int i = 0; i < seq.size(); i++) begin
      p = seq[i] ? int'($urandom_range(36, 24)) : int'($urandom_range(90, 72));
      send_cycle(p, glitchy);
    end
    tail_edge(rw);
  endtask

  task automatic do_rewind();
    @(negedge clk) rewind = 1'b1;
    @(negedge clk) rewind = 1'b0;
    model_clear();
  endtask

  task automatic check_writes(input string tag);
    int n;
    check({tag, " wr_count"}, wq_data.size(), exp_data.size());
    n = (wq_data.size() < exp_data.size()) ? wq_data.size() : exp_data.size();
    for (int i = 0; i < n; i++) begin
      check({tag, " wr_data"}, wq_data[i], exp_data[i]);
      check({tag, " wr_addr"}, wq_addr[i], exp_addr[i]);
    end
    wq_data.delete();
    wq_addr.delete();
    exp_data.delete();
    exp_addr.delete();
    check({tag, " ram_addr"}, ram_addr, m_addr);
    check({tag, " rec_len"}, rec_len, m_len);
    check({tag, " full"}, full, m_full);
    check({tag, " active"}, active, 0);
  endtask

  initial begin
    reset_n = 1'b0;
    en      = 1'b0;
    rewind  = 1'b0;
    sound   = 6'd0;
    model_clear();
    repeat (3) @(negedge clk);
    check("rst ram_addr", ram_addr, 0);
    check("rst ram_din", ram_din, 0);
    check("rst ram_we", ram_we, 0);
    check("rst rec_len", rec_len, 0);
    check("rst active", active, 0);
    check("rst full", full, 0);
    reset_n = 1'b1;
    en      = 1'b1;
    repeat (5) @(negedge clk);

    // 1200 Hz only: one zero byte
    seq.delete(); load_byte(8'h00); play(1'b0, 1'b0); model_play(); check_writes("zeros");

    // alternating 2400/1200 Hz: 0x55
    do_rewind();
    seq.delete(); load_byte(8'h55); play(1'b0, 1'b0); model_play(); check_writes("x55");

    // glitch spikes inside every cycle are ignored
    seq.delete(); load_byte(8'h55); play(1'b1, 1'b0); model_play(); check_writes("glitch");

    // partial byte lost on silence, then 0x3C
    do_rewind();
    seq.delete(); load_rand(5); play(1'b0, 1'b0);
    seq.delete(); load_byte(8'h3C); play(1'b0, 1'b0); model_play(); check_writes("timeout");

    // relay drop mid-byte discards the partial byte
    for (int i = 0; i < 4; i++) send_cycle(int'($urandom_range(36, 24)), 1'b0);
    check("endrop active_on", active, 1);
    @(negedge clk) begin en = 1'b0; sound = 6'd0; end
    repeat (3) @(negedge clk);
    check("endrop active_off", active, 0);
    check("endrop no_write", wq_data.size(), 0);
    repeat (20) @(negedge clk);
    en = 1'b1;
    silence(8);
    seq.delete(); load_byte(8'hA7); play(1'b0, 1'b0); model_play(); check_writes("endrop");

    // rewind on the clk the 8th bit lands
    seq.delete(); load_byte(8'($urandom)); play(1'b0, 1'b1); model_clear(); check_writes("rewind8");

    // fill the SRAM, then one more byte
    do_rewind();
    seq.delete(); load_rand(40); play(1'b0, 1'b0); model_play(); check_writes("full");

    // randomized recordings
    for (int r = 0; r < 4; r++) begin
      do_rewind();
      seq.delete(); load_rand(int'($urandom_range(20, 8)));
      play(1'($urandom_range(1, 0)), 1'b0); model_play(); check_writes("random");
    end

    // asynchronous reset in the middle of a byte
    do_rewind();
    seq.delete(); load_byte(8'($urandom)); play(1'b0, 1'b0); model_play(); check_writes("prereset");
    for (int i = 0; i < 3; i++) send_cycle(int'($urandom_range(90, 72)), 1'b0);
    @(negedge clk);
    #1 reset_n = 1'b0;
    #1;
    check("areset ram_addr", ram_addr, 0);
    check("areset ram_din", ram_din, 0);
    check("areset ram_we", ram_we, 0);
    check("areset rec_len", rec_len, 0);
    check("areset active", active, 0);
    check("areset full", full, 0);
    model_clear();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    silence(SIL_CLKS);
    check_writes("postreset");

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
